// File: rtl/mpsoc_msi_wb_arbiter.sv
// Round-robin Wishbone B3 arbiter that grants whole bus cycles from NUM_MASTERS masters to one slave.
// Define MPSOC_MSI_WB_ARB_TIMEOUT_EN to add a watchdog that turns a hung slave into a bus error.
module mpsoc_msi_wb_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic [NUM_MASTERS*AW-1:0]   m_adr_i,
    input  logic [NUM_MASTERS*DW-1:0]   m_dat_i,
    input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
    input  logic [NUM_MASTERS*3-1:0]    m_cti_i,
    input  logic [NUM_MASTERS*2-1:0]    m_bte_i,
    input  logic [NUM_MASTERS-1:0]      m_we_i,
    input  logic [NUM_MASTERS-1:0]      m_cyc_i,
    input  logic [NUM_MASTERS-1:0]      m_stb_i,
    output logic [DW-1:0]               m_dat_o,
    output logic [NUM_MASTERS-1:0]      m_ack_o,
    output logic [NUM_MASTERS-1:0]      m_err_o,
    output logic [NUM_MASTERS-1:0]      m_rty_o,
    output logic [AW-1:0]               s_adr_o,
    output logic [DW-1:0]               s_dat_o,
    output logic [DW/8-1:0]             s_sel_o,
    output logic                        s_we_o,
    output logic                        s_cyc_o,
    output logic                        s_stb_o,
    output logic [2:0]                  s_cti_o,
    output logic [1:0]                  s_bte_o,
    input  logic [DW-1:0]               s_dat_i,
    input  logic                        s_ack_i,
    input  logic                        s_err_i,
    input  logic                        s_rty_i,
    output logic [NUM_MASTERS-1:0]      grant_o
);
    localparam int GW = $clog2(NUM_MASTERS);
    localparam int SW = DW / 8;

    if (NUM_MASTERS < 2 || TIMEOUT < 1) begin : gParamCheck
        $error("mpsoc_msi_wb_arbiter: NUM_MASTERS must be >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic {IDLE, BUSY} state_e;

    state_e                 state_q, state_d;
    logic [GW-1:0]          gidx_q, gidx_d;
    logic [GW-1:0]          last_q, last_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [GW-1:0]          pick;
    int                     cand;

    logic [AW-1:0] adrArr [NUM_MASTERS];
    logic [DW-1:0] datArr [NUM_MASTERS];
    logic [SW-1:0] selArr [NUM_MASTERS];
    logic [2:0]    ctiArr [NUM_MASTERS];
    logic [1:0]    bteArr [NUM_MASTERS];

    for (genvar k = 0; k < NUM_MASTERS; k++) begin : gUnpack
        assign adrArr[k] = m_adr_i[k*AW +: AW];
        assign datArr[k] = m_dat_i[k*DW +: DW];
        assign selArr[k] = m_sel_i[k*SW +: SW];
        assign ctiArr[k] = m_cti_i[k*3 +: 3];
        assign bteArr[k] = m_bte_i[k*2 +: 2];
    end

    // Scanning downward leaves the requester closest after last_q as the winner.
    always_comb begin
        pick = last_q;
        cand = 0;
        for (int i = NUM_MASTERS; i >= 1; i--) begin
            cand = (int'(last_q) + i) % NUM_MASTERS;
            if (m_cyc_i[GW'(cand)]) pick = GW'(cand);
        end
    end

`ifdef MPSOC_MSI_WB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wdCnt_q, wdCnt_d;
    logic          timeout;

    assign timeout = (state_q == BUSY) && (wdCnt_q == CW'(TIMEOUT));

    always_comb begin
        wdCnt_d = wdCnt_q;
        if (state_q != BUSY || timeout || s_ack_i || s_err_i || s_rty_i) wdCnt_d = '0;
        else if (m_stb_i[gidx_q]) wdCnt_d = wdCnt_q + 1'b1;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) wdCnt_q <= '0;
        else          wdCnt_q <= wdCnt_d;
    end
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            gidx_q  <= '0;
            last_q  <= GW'(NUM_MASTERS - 1);
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            grant_q <= grant_d;
        end
    end

    // A grant is only ever released by the owning master dropping cyc.
    always_comb begin
        state_d = state_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        grant_d = grant_q;
        unique case (state_q)
            IDLE: begin
                if (|m_cyc_i) begin
                    gidx_d  = pick;
                    grant_d = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << pick;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!m_cyc_i[gidx_q]) begin
                    last_d  = gidx_q;
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_cti_o = '0;
        s_bte_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        m_rty_o = '0;
        if (state_q == BUSY) begin
            s_adr_o = adrArr[gidx_q];
            s_dat_o = datArr[gidx_q];
            s_sel_o = selArr[gidx_q];
            s_we_o  = m_we_i[gidx_q];
            s_cyc_o = m_cyc_i[gidx_q];
            s_stb_o = m_stb_i[gidx_q];
            s_cti_o = ctiArr[gidx_q];
            s_bte_o = bteArr[gidx_q];
            m_ack_o[gidx_q] = s_ack_i;
            m_err_o[gidx_q] = s_err_i;
            m_rty_o[gidx_q] = s_rty_i;
`ifdef MPSOC_MSI_WB_ARB_TIMEOUT_EN
            if (timeout) begin
                s_cyc_o = 1'b0;
                s_stb_o = 1'b0;
                m_err_o[gidx_q] = 1'b1;
            end
`endif
        end
    end

    assign m_dat_o = s_dat_i;
    assign grant_o = grant_q;

endmodule
